ce_divider_bank: RTL and testbench
==================================

# ce_divider_bank

Parametrised clock-enable generator for the core's video and CPU timing. It runs on a single fast system clock and produces NUM_CH phase-aligned clock-enable strobes, each with a runtime-programmable divisor and phase offset. It replaces fixed PLL output taps, so pixel and CPU domains become enables on one clock. It also gates all strobes on PLL lock and supports glitch-free runtime reprogramming.

## Interface

Parameters:
- NUM_CH, 3: number of enable channels (1..8).
- DIV_W, 8: width of divisor and phase fields.
- LOCK_HOLD, 16: cycles that synchronised lock must stay high before strobes start (≥1).
- DEF_DIV, {8'd4,8'd4,8'd2}: flattened NUM_CH×DIV_W reset divisors; channel 0 is in the LSBs.
- DEF_PHASE, {8'd2,8'd0,8'd0}: flattened NUM_CH×DIV_W reset phases.

Ports:
- clk, input, 1: system clock; all logic is on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- pll_locked, input, 1: PLL lock, asynchronous to clk.
- resync, input, 1: single-cycle pulse that realigns all channels.
- cfg_valid, input, 1: configuration request.
- cfg_ready, output, 1: high when the shadow register is free.
- cfg_ch, input, 3: target channel index.
- cfg_div, input, DIV_W: new divisor D.
- cfg_phase, input, DIV_W: new phase P.
- ce, output, NUM_CH: registered enable strobes, one per channel.
- ready, output, 1: strobes running.

## Operation

- Reset values: ce=0, ready=0, cfg_ready=1. Divisor/phase registers load DEF_DIV/DEF_PHASE. Counters and the hold counter are 0. Synchroniser flops are 0.
- pll_locked passes through a 2-flop synchroniser to produce lk.
- States:
  - WAIT: lk=0. Hold counter is cleared.
  - HOLD: lk=1. Hold counter increments each cycle. On reaching LOCK_HOLD, go to RUN. lk=0 returns to WAIT.
  - RUN: ready=1. lk=0 returns to WAIT in one cycle: ready and ce drop on the next edge, and counters clear.
- Channel counter counts 0..Deff−1 in RUN, wraps to 0, and is held at 0 outside RUN.
  - Deff = max(D,1).
  - Peff = min(P, Deff−1).
  - ce[i] is registered from (RUN && cnt==Peff), so it is high for exactly one cycle every Deff cycles.
  - Deff=1 gives ce held continuously high.
- resync in RUN clears all counters on the next edge and drives ce=0 for that cycle. resync outside RUN is ignored.
- Configuration handshake:
  - A request is accepted when cfg_valid && cfg_ready. It loads the shadow register, and cfg_ready goes low on the next cycle.
  - Outside RUN, the shadow applies on the next edge.
  - In RUN, it applies on the edge where the target counter is at Deff−1. The new D/P take effect, the counter restarts at 0, and no strobe is lost or duplicated.
  - cfg_ready returns high the cycle after apply.
  - cfg_ch ≥ NUM_CH is accepted and discarded; cfg_ready goes high again after one cycle.
- Simultaneous events:
  - resync together with an apply: the config applies and all counters go to 0.
  - Lock loss with a pending shadow: the shadow is kept and applies in WAIT.
- All arithmetic is unsigned DIV_W. Counter compares use Deff−1 without overflow, since D=0 is clamped.

## Timing

- pll_locked rising at edge k gives lk=1 at edge k+2, and ready rises at edge k+2+LOCK_HOLD. Call that edge R.
- First ce[i] occurs in cycle R+1+Peff, then repeats every Deff cycles.
- resync sampled at edge s: counters are 0 after s, and the first strobe is at s+1+Peff.
- Config accepted at edge a: cfg_ready is low from a+1 until the cycle after apply. The worst-case apply is a+old Deff.
- No combinational path exists from any input to any output.

## Structure

- Package ce_bank_pkg holds:
  - the DIV_W default;
  - the state enum {WAIT,HOLD,RUN};
  - the functions clamp_div(D) and clamp_phase(P,Deff).
- Sub-module ce_channel holds one counter, the D/P registers, the apply logic and the ce flop. The top level instantiates NUM_CH of them.
- The top level holds the lock synchroniser, the hold FSM, the shadow register and the handshake.

## Test plan

- Default parameters, pll_locked=1 from cycle 5, LOCK_HOLD=16 -> ready rises at cycle 23. ce[0] then pulses every 2 cycles starting at R+1. ce[1] pulses every 4 starting at R+1. ce[2] pulses every 4 starting at R+3.
- pll_locked dropped for 3 cycles mid-RUN -> ready and ce go to 0 within 3 cycles. After re-lock plus 18 cycles, strobes restart aligned as in the first scenario.
- Config ch1 D=3 P=1 accepted while cnt1=1 -> old period completes, the counter restarts at the next wrap, and the next ce[1] is 2 cycles after apply, then every 3. cfg_ready stays low until the cycle after apply.
- Edge configs: D=0 -> ce held high; D=5 P=9 -> phase clamped to 4; cfg_ch=7 -> no channel changes and cfg_ready high again after 1 cycle.
- resync pulse in RUN -> all ce low the next cycle, and channels realign per Peff. Pulse coinciding with an apply -> new config active with all counters at 0.
- reset_n asserted mid-RUN with a pending config -> all outputs go to reset values immediately and asynchronously, and the shadow is discarded.

Source files
------------

// File: rtl/ce_bank_pkg.sv
// Shared types and clamp helpers for the clock-enable divider bank.
// Helpers work at CE_CALC_W bits; callers zero-extend and narrow explicitly.
package ce_bank_pkg;

  localparam int unsigned CE_DIV_W  = 8;
  localparam int unsigned CE_CALC_W = 32;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // A divisor of zero behaves as divide-by-one.
  function automatic logic [CE_CALC_W-1:0] clamp_div(input logic [CE_CALC_W-1:0] d);
    return (d == '0) ? CE_CALC_W'(1) : d;
  endfunction

  // Phase is limited to the last count of the period; deff is never zero.
  function automatic logic [CE_CALC_W-1:0] clamp_phase(input logic [CE_CALC_W-1:0] p,
                                                      input logic [CE_CALC_W-1:0] deff);
    return (p >= deff) ? (deff - CE_CALC_W'(1)) : p;
  endfunction

endpackage

// File: rtl/ce_channel.sv
// One enable channel: wrap counter, effective divisor/phase registers and the
// strobe flop. New settings take over only on a period boundary while running.
module ce_channel
  import ce_bank_pkg::*;
#(
  parameter int unsigned      DIV_W     = CE_DIV_W,
  parameter logic [DIV_W-1:0] DEF_DIV   = DIV_W'(1),
  parameter logic [DIV_W-1:0] DEF_PHASE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_i,
  input  logic             resync_i,
  input  logic             apply_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  output logic             applied_o,
  output logic             ce_o
);

  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
  localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(clamp_div(CE_CALC_W'(DEF_DIV)));
  localparam logic [DIV_W-1:0] RST_PHASE =
    DIV_W'(clamp_phase(CE_CALC_W'(DEF_PHASE), CE_CALC_W'(RST_DIV)));

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic             ce_q, ce_d;
  logic [DIV_W-1:0] new_div, new_phase;
  logic             at_wrap;

  assign new_div   = DIV_W'(clamp_div(CE_CALC_W'(div_i)));
  assign new_phase = DIV_W'(clamp_phase(CE_CALC_W'(phase_i), CE_CALC_W'(new_div)));

  // div_q is always >= 1, so the subtraction cannot wrap.
  assign at_wrap   = (cnt_q == (div_q - ONE));
  assign applied_o = apply_i && (!run_i || at_wrap);

  always_comb begin
    cnt_d   = '0;
    div_d   = div_q;
    phase_d = phase_q;
    ce_d    = 1'b0;
    if (run_i) begin
      ce_d  = (cnt_q == phase_q) && !resync_i;
      cnt_d = (at_wrap || resync_i) ? '0 : (cnt_q + ONE);
    end
    if (applied_o) begin
      div_d   = new_div;
      phase_d = new_phase;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      div_q   <= RST_DIV;
      phase_q <= RST_PHASE;
      ce_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      ce_q    <= ce_d;
    end
  end

  assign ce_o = ce_q;

endmodule

// File: rtl/ce_divider_bank.sv
// Bank of phase-aligned clock enables on one system clock, gated by a
// synchronised and debounced PLL lock, with a one-deep configuration shadow.
module ce_divider_bank
  import ce_bank_pkg::*;
#(
  parameter int unsigned              NUM_CH    = 3,
  parameter int unsigned              DIV_W     = CE_DIV_W,
  parameter int unsigned              LOCK_HOLD = 16,
  parameter logic [NUM_CH*DIV_W-1:0]  DEF_DIV   = {8'd4, 8'd4, 8'd2},
  parameter logic [NUM_CH*DIV_W-1:0]  DEF_PHASE = {8'd2, 8'd0, 8'd0}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic              resync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] ce,
  output logic              ready
);

  localparam int unsigned       HOLD_W   = $clog2(LOCK_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(LOCK_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [3:0]        NUM_CH_L = 4'(NUM_CH);

  logic [1:0]        sync_q;
  logic              lk;
  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ready_q;
  logic              run_en;

  logic              sh_vld_q, sh_hit_q;
  logic [2:0]        sh_ch_q;
  logic [DIV_W-1:0]  sh_div_q, sh_phase_q;
  logic              accept, sh_done;
  logic [NUM_CH-1:0] apply_vec, applied;

  assign lk = sync_q[1];

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      WAIT: begin
        hold_d = '0;
        if (lk) state_d = HOLD;
      end
      HOLD: begin
        if (!lk) begin
          state_d = WAIT;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_ONE;
          if (hold_d == HOLD_END) state_d = RUN;
        end
      end
      RUN: begin
        if (!lk) state_d = WAIT;
      end
      default: state_d = WAIT;
    endcase
  end

  // Channels stop on the same edge that ready drops when lock is lost.
  assign run_en = (state_q == RUN) && lk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b00;
      state_q <= WAIT;
      hold_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pll_locked};
      state_q <= state_d;
      hold_q  <= hold_d;
      ready_q <= (state_d == RUN);
    end
  end

  assign accept  = cfg_valid && !sh_vld_q;
  assign sh_done = sh_vld_q && (!sh_hit_q || (|applied));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_vld_q   <= 1'b0;
      sh_hit_q   <= 1'b0;
      sh_ch_q    <= '0;
      sh_div_q   <= '0;
      sh_phase_q <= '0;
    end else if (accept) begin
      sh_vld_q   <= 1'b1;
      sh_hit_q   <= ({1'b0, cfg_ch} < NUM_CH_L);
      sh_ch_q    <= cfg_ch;
      sh_div_q   <= cfg_div;
      sh_phase_q <= cfg_phase;
    end else if (sh_done) begin
      sh_vld_q   <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign apply_vec[i] = sh_vld_q && sh_hit_q && (sh_ch_q == 3'(i));

    ce_channel #(
      .DIV_W    (DIV_W),
      .DEF_DIV  (DEF_DIV[i*DIV_W +: DIV_W]),
      .DEF_PHASE(DEF_PHASE[i*DIV_W +: DIV_W])
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .run_i    (run_en),
      .resync_i (resync),
      .apply_i  (apply_vec[i]),
      .div_i    (sh_div_q),
      .phase_i  (sh_phase_q),
      .applied_o(applied[i]),
      .ce_o     (ce[i])
    );
  end

  assign cfg_ready = !sh_vld_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_ce_divider_bank.sv
// Randomised bench for ce_divider_bank against an arithmetic phase-origin model.
module tb_ce_divider_bank;

  localparam int NUM_CH    = 3;
  localparam int DIV_W     = 8;
  localparam int LOCK_HOLD = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              pll_locked;
  logic              resync;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_phase;
  logic [NUM_CH-1:0] ce;
  logic              ready;

  always #5 clk = ~clk;

  ce_divider_bank #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .LOCK_HOLD(LOCK_HOLD),
    .DEF_DIV  ({8'd4, 8'd4, 8'd2}),
    .DEF_PHASE({8'd2, 8'd0, 8'd0})
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .resync    (resync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .ce        (ce),
    .ready     (ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: each channel strobes when (edges since origin - 1) mod D == P.
  int                t_edge;
  int                h0, h1, h2;
  int                md[NUM_CH], mp[NUM_CH], morg[NUM_CH];
  bit                pend, pend_hit;
  int                pend_ch, pend_d, pend_p;
  logic [NUM_CH-1:0] exp_ce;
  bit                exp_ready, exp_cfg_ready;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, t_edge, got, exp);
    end
  endtask

  function automatic int eff_d(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int eff_p(input int p, input int d);
    return (p > d - 1) ? d - 1 : p;
  endfunction

  task automatic model_reset();
    int dd[NUM_CH];
    int pp[NUM_CH];
    dd = '{2, 4, 4};
    pp = '{0, 0, 2};
    t_edge = 0;
    h0 = 0; h1 = 0; h2 = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      md[i]   = eff_d(dd[i]);
      mp[i]   = eff_p(pp[i], md[i]);
      morg[i] = 0;
    end
    pend = 0; pend_hit = 0; pend_ch = 0; pend_d = 0; pend_p = 0;
    exp_ce = '0; exp_ready = 0; exp_cfg_ready = 1;
  endtask

  task automatic model_edge();
    int                n0;
    bit                rdy_now, run, pend_before;
    logic [NUM_CH-1:0] ce_n;
    t_edge++;
    n0 = (pll_locked === 1'b1) ? h0 + 1 : 0;
    h2 = h1; h1 = h0; h0 = n0;
    // Strobes run once lock has been seen for LOCK_HOLD+1 consecutive samples.
    rdy_now     = (h2 >= LOCK_HOLD + 1);
    run         = exp_ready && rdy_now;
    pend_before = pend;
    ce_n        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bit app;
      app = pend_before && pend_hit && (pend_ch == i) &&
            (!run || ((t_edge - morg[i]) % md[i] == 0));
      if (run && !resync) ce_n[i] = (((t_edge - 1 - morg[i]) % md[i]) == mp[i]);
      if (!run || resync) morg[i] = t_edge;
      if (app) begin
        md[i]   = eff_d(pend_d);
        mp[i]   = eff_p(pend_p, md[i]);
        morg[i] = t_edge;
        pend    = 0;
      end
    end
    if (pend_before && !pend_hit) pend = 0;
    if (cfg_valid && !pend_before) begin
      pend     = 1;
      pend_ch  = int'(cfg_ch);
      pend_d   = int'(cfg_div);
      pend_p   = int'(cfg_phase);
      pend_hit = (int'(cfg_ch) < NUM_CH);
    end
    exp_ce        = ce_n;
    exp_ready     = rdy_now;
    exp_cfg_ready = !pend;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_val("ce", 32'(ce), 32'(exp_ce));
    check_val("ready", 32'(ready), 32'(exp_ready));
    check_val("cfg_ready", 32'(cfg_ready), 32'(exp_cfg_ready));
  endtask

  task automatic send_cfg(input int ch, input int d, input int p);
    int k;
    k = 0;
    while (cfg_ready !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    check_val("cfg_slot_free", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_div   = 8'(d);
    cfg_phase = 8'(p);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int e0, t_rise, k, drop_left;
    reset_n = 1'b0; pll_locked = 1'b0; resync = 1'b0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ce", 32'(ce), 32'd0);
    check_val("rst_ready", 32'(ready), 32'd0);
    check_val("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    reset_n = 1'b1;

    // Initial lock and default strobe pattern.
    repeat (5) tick();
    pll_locked = 1'b1;
    e0 = t_edge + 1;
    t_rise = -1;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (ready === 1'b1 && t_rise < 0) t_rise = t_edge;
    end
    check_val("ready_rise_edge", 32'(t_rise), 32'(e0 + 2 + LOCK_HOLD));

    // Short lock loss mid-run, then re-lock.
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    repeat (40) tick();

    // Reprogram ch1 just after its strobe so the counter sits at 1 when accepted.
    k = 0;
    while (ce[1] !== 1'b1 && k < 16) begin
      tick();
      k++;
    end
    check_val("ce1_seen", 32'(ce[1]), 32'd1);
    send_cfg(1, 3, 1);
    repeat (12) tick();

    send_cfg(0, 0, 0);
    repeat (10) tick();
    send_cfg(2, 5, 9);
    repeat (15) tick();
    send_cfg(7, 3, 3);
    repeat (4) tick();

    resync = 1'b1;
    tick();
    resync = 1'b0;
    repeat (12) tick();

    // Resync landing on the same edge as an apply (ch0 has D=1, so it applies at once).
    send_cfg(0, 3, 2);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    repeat (12) tick();

    drop_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (drop_left > 0) begin
        drop_left--;
        pll_locked = (drop_left == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        drop_left  = int'($urandom_range(1, 4));
        pll_locked = 1'b0;
      end
      resync    = ($urandom_range(0, 19) == 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_ch    = 3'($urandom_range(0, 4));
      cfg_div   = 8'($urandom_range(0, 9));
      cfg_phase = 8'($urandom_range(0, 11));
      tick();
    end
    resync = 1'b0; cfg_valid = 1'b0; pll_locked = 1'b1;
    repeat (30) tick();

    // Asynchronous reset while a configuration is still waiting for its wrap.
    send_cfg(2, 9, 0);
    send_cfg(2, 2, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_rst_ce", 32'(ce), 32'd0);
    check_val("async_rst_ready", 32'(ready), 32'd0);
    check_val("async_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    repeat (60) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
